// File: rtl/raid_pkg.sv
// Shared types and address-decode helpers for the RAID read controller.
package raid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int unsigned MAX_DISKS  = 32;
  localparam int unsigned MAX_ADDR_W = 32;

  function automatic int unsigned parity_disk(input logic [MAX_ADDR_W-1:0] addr,
                                              input int unsigned n);
    return addr % n;
  endfunction

  // A degraded array whose failed disk is the parity disk reads like a healthy one.
  function automatic logic [MAX_DISKS-1:0] read_mask(input int unsigned p,
                                                     input logic degraded,
                                                     input int unsigned failed,
                                                     input int unsigned n);
    logic [MAX_DISKS-1:0] m;
    m = {MAX_DISKS{1'b1}} >> (MAX_DISKS - n);
    if (degraded && (failed < n) && (failed != p)) begin
      m = m & ~(MAX_DISKS'(1'b1) << failed);
    end else begin
      m = m & ~(MAX_DISKS'(1'b1) << p);
    end
    return m;
  endfunction

endpackage

// File: rtl/raid_xor_rebuild.sv
// Packs the non-parity disk blocks into response slots, substituting the block
// reconstructed by XOR of every disk that was read for the missing disk.
module raid_xor_rebuild #(
  parameter int N_DISKS = 3,
  parameter int DATA_W  = 12
) (
  input  logic [N_DISKS*DATA_W-1:0]     mem_data,
  input  logic [N_DISKS-1:0]            mask,
  input  logic [$clog2(N_DISKS)-1:0]    parity,
  input  logic [$clog2(N_DISKS)-1:0]    missing,
  output logic [(N_DISKS-1)*DATA_W-1:0] slots
);

  logic [DATA_W-1:0] rebuilt_s;

  // XOR of all blocks actually read
  always_comb begin
    rebuilt_s = '0;
    for (int d = 0; d < N_DISKS; d++) begin
      if (mask[d]) begin
        rebuilt_s = rebuilt_s ^ mem_data[d*DATA_W +: DATA_W];
      end else begin
        rebuilt_s = rebuilt_s;
      end
    end
  end

  // slot k maps to disk k, or k+1 once the parity disk has been skipped
  always_comb begin
    int p_i;
    int m_i;
    int d;
    slots = '0;
    p_i   = int'(parity);
    m_i   = int'(missing);
    for (int k = 0; k < N_DISKS - 1; k++) begin
      if (k >= p_i) begin
        d = k + 1;
      end else begin
        d = k;
      end
      if (d == m_i) begin
        slots[k*DATA_W +: DATA_W] = rebuilt_s;
      end else begin
        slots[k*DATA_W +: DATA_W] = mem_data[d*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/raid_read_ctrl.sv
// RAID read controller: rotating-parity decode, one-shot disk read, timed wait
// for the memory response and a held response with optional block rebuild.
module raid_read_ctrl
  import raid_pkg::*;
#(
  parameter int N_DISKS = 3,
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rd_valid,
  output logic                          rd_ready,
  input  logic [ADDR_W-1:0]             rd_add,
  input  logic                          degraded,
  input  logic [$clog2(N_DISKS)-1:0]    failed_disk,
  output logic [N_DISKS-1:0]            mem_en,
  output logic [ADDR_W-1:0]             mem_add,
  input  logic                          mem_valid,
  input  logic [N_DISKS*DATA_W-1:0]     mem_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(N_DISKS-1)*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]             out_add,
  output logic                          out_err,
  output logic                          out_rebuilt
);

  localparam int P_W   = $clog2(N_DISKS);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int OUT_W = (N_DISKS - 1) * DATA_W;

  state_t             state_r, state_nxt_s;
  logic [ADDR_W-1:0]  addr_r;
  logic [P_W-1:0]     parity_r, missing_r;
  logic [N_DISKS-1:0] mask_r;
  logic               rebuild_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               timeout_s;

  logic [P_W-1:0]     p_idx_s, missing_s;
  logic [N_DISKS-1:0] mask_s;
  logic               failed_ok_s, rebuild_s;
  logic [OUT_W-1:0]   slots_s;

  logic [N_DISKS-1:0] mem_en_r, mem_en_nxt_s;
  logic [ADDR_W-1:0]  mem_add_r, mem_add_nxt_s;
  logic               out_valid_r, out_valid_nxt_s;
  logic [OUT_W-1:0]   out_data_r, out_data_nxt_s;
  logic [ADDR_W-1:0]  out_add_r, out_add_nxt_s;
  logic               out_err_r, out_err_nxt_s;
  logic               out_rebuilt_r, out_rebuilt_nxt_s;

  // Decode of the request currently presented on the user port
  always_comb begin
    p_idx_s     = P_W'(parity_disk(MAX_ADDR_W'(rd_add), N_DISKS));
    mask_s      = N_DISKS'(read_mask(32'(p_idx_s), degraded, 32'(failed_disk), N_DISKS));
    failed_ok_s = (32'(failed_disk) < 32'(N_DISKS));
    rebuild_s   = degraded && failed_ok_s && (failed_disk != p_idx_s);
    if (rebuild_s) begin
      missing_s = failed_disk;
    end else begin
      missing_s = p_idx_s;
    end
  end

  raid_xor_rebuild #(.N_DISKS(N_DISKS), .DATA_W(DATA_W)) u_rebuild (
    .mem_data (mem_data),
    .mask     (mask_r),
    .parity   (parity_r),
    .missing  (missing_r),
    .slots    (slots_s)
  );

  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));
  assign rd_ready  = (state_r == ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_valid) state_nxt_s = ST_ISSUE;
        else          state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (mem_valid || timeout_s) state_nxt_s = ST_RESP;
        else                        state_nxt_s = ST_WAIT;
      end
      ST_RESP: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; response data wins over timeout
  always_comb begin
    mem_en_nxt_s      = '0;
    mem_add_nxt_s     = '0;
    out_valid_nxt_s   = out_valid_r;
    out_data_nxt_s    = out_data_r;
    out_add_nxt_s     = out_add_r;
    out_err_nxt_s     = out_err_r;
    out_rebuilt_nxt_s = out_rebuilt_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_valid) begin
          mem_en_nxt_s  = mask_s;
          mem_add_nxt_s = rd_add;
        end else begin
          mem_en_nxt_s  = '0;
          mem_add_nxt_s = '0;
        end
      end
      ST_ISSUE: begin
        mem_en_nxt_s = '0;
      end
      ST_WAIT: begin
        if (mem_valid) begin
          out_valid_nxt_s   = 1'b1;
          out_data_nxt_s    = slots_s;
          out_add_nxt_s     = addr_r;
          out_err_nxt_s     = 1'b0;
          out_rebuilt_nxt_s = rebuild_r;
        end else if (timeout_s) begin
          out_valid_nxt_s   = 1'b1;
          out_data_nxt_s    = '0;
          out_add_nxt_s     = addr_r;
          out_err_nxt_s     = 1'b1;
          out_rebuilt_nxt_s = 1'b0;
        end else begin
          out_valid_nxt_s = 1'b0;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          out_valid_nxt_s   = 1'b0;
          out_data_nxt_s    = '0;
          out_add_nxt_s     = '0;
          out_err_nxt_s     = 1'b0;
          out_rebuilt_nxt_s = 1'b0;
        end else begin
          out_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        out_valid_nxt_s   = 1'b0;
        out_data_nxt_s    = '0;
        out_add_nxt_s     = '0;
        out_err_nxt_s     = 1'b0;
        out_rebuilt_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_en_r      <= '0;
      mem_add_r     <= '0;
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      out_add_r     <= '0;
      out_err_r     <= 1'b0;
      out_rebuilt_r <= 1'b0;
    end else begin
      mem_en_r      <= mem_en_nxt_s;
      mem_add_r     <= mem_add_nxt_s;
      out_valid_r   <= out_valid_nxt_s;
      out_data_r    <= out_data_nxt_s;
      out_add_r     <= out_add_nxt_s;
      out_err_r     <= out_err_nxt_s;
      out_rebuilt_r <= out_rebuilt_nxt_s;
    end
  end

  // Request context captured on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r    <= '0;
      parity_r  <= '0;
      missing_r <= '0;
      mask_r    <= '0;
      rebuild_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && rd_valid) begin
      addr_r    <= rd_add;
      parity_r  <= p_idx_s;
      missing_r <= missing_s;
      mask_r    <= mask_s;
      rebuild_r <= rebuild_s;
    end
  end

  // Wait-cycle counter, cleared outside WAIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= '0;
    end
  end

  assign mem_en      = mem_en_r;
  assign mem_add     = mem_add_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_add     = out_add_r;
  assign out_err     = out_err_r;
  assign out_rebuilt = out_rebuilt_r;

endmodule

// File: tb/tb_raid_read_ctrl.sv
// Directed bench for raid_read_ctrl (N_DISKS=3, DATA_W=12, TIMEOUT=15): vector
// table for decode/rebuild plus timeout, backpressure and reset sequences.
module tb_raid_read_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [7:0]  rd_add = 8'h00;
  logic        degraded = 1'b0;
  logic [1:0]  failed_disk = 2'd0;
  logic [2:0]  mem_en;
  logic [7:0]  mem_add;
  logic        mem_valid = 1'b0;
  logic [35:0] mem_data = 36'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_data;
  logic [7:0]  out_add;
  logic        out_err;
  logic        out_rebuilt;

  int n_checks = 0;
  int n_fail   = 0;

  raid_read_ctrl #(.N_DISKS(3), .DATA_W(12), .ADDR_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_add(rd_add), .degraded(degraded), .failed_disk(failed_disk),
    .mem_en(mem_en), .mem_add(mem_add), .mem_valid(mem_valid), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_add(out_add), .out_err(out_err), .out_rebuilt(out_rebuilt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic        degr;
    logic [1:0]  fd;
    logic [11:0] d0, d1, d2;
    logic [2:0]  en;
    logic [23:0] data;
    logic        rb;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic accept(input logic [7:0] a, input logic dg, input logic [1:0] fd);
    check("rd_ready_idle", 32'(rd_ready), 32'd1);
    rd_valid = 1'b1; rd_add = a; degraded = dg; failed_disk = fd;
    @(posedge clk); #1;
    rd_valid = 1'b0; rd_add = 8'h00; degraded = 1'b0; failed_disk = 2'd0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_clr", 32'(out_valid), 32'd0);
    check("out_data_clr", 32'(out_data), 32'd0);
    check("out_err_clr", 32'(out_err), 32'd0);
    check("rd_ready_back", 32'(rd_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    accept(v.addr, v.degr, v.fd);
    check("mem_en", 32'(mem_en), 32'(v.en));
    check("mem_add", 32'(mem_add), 32'(v.addr));
    check("rd_ready_busy", 32'(rd_ready), 32'd0);
    // held from ISSUE so the earliest legal sample is the first WAIT edge
    mem_data = {v.d2, v.d1, v.d0}; mem_valid = 1'b1;
    @(posedge clk); #1;
    check("mem_en_pulse", 32'(mem_en), 32'd0);
    check("out_valid_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_data = 36'h0;
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_data", 32'(out_data), 32'(v.data));
    check("out_add", 32'(out_add), 32'(v.addr));
    check("out_err", 32'(out_err), 32'd0);
    check("out_rebuilt", 32'(out_rebuilt), 32'(v.rb));
    handshake();
  endtask

  initial begin
    int early;
    //           addr   dg    fd     d0       d1       d2       en      data                rb
    vecs[0] = '{8'h05, 1'b0, 2'd0, 12'h111, 12'h222, 12'hABC, 3'b011, {12'h222, 12'h111}, 1'b0};
    vecs[1] = '{8'h03, 1'b0, 2'd0, 12'h123, 12'h456, 12'h789, 3'b110, {12'h789, 12'h456}, 1'b0};
    vecs[2] = '{8'h04, 1'b0, 2'd0, 12'hA01, 12'hB02, 12'hC03, 3'b101, {12'hC03, 12'hA01}, 1'b0};
    vecs[3] = '{8'h03, 1'b1, 2'd1, 12'h0F0, 12'hFFF, 12'h0AA, 3'b101, {12'h0AA, 12'h05A}, 1'b1};
    vecs[4] = '{8'h05, 1'b1, 2'd2, 12'h321, 12'h654, 12'h987, 3'b011, {12'h654, 12'h321}, 1'b0};
    vecs[5] = '{8'h04, 1'b1, 2'd3, 12'h5A5, 12'h000, 12'h3C3, 3'b101, {12'h3C3, 12'h5A5}, 1'b0};
    vecs[6] = '{8'h04, 1'b1, 2'd0, 12'hAAA, 12'h00F, 12'h0F0, 3'b110, {12'h0F0, 12'h0FF}, 1'b1};
    vecs[7] = '{8'hFF, 1'b0, 2'd0, 12'h001, 12'h802, 12'h403, 3'b110, {12'h403, 12'h802}, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_ready", 32'(rd_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Timeout at accept+16, then backpressure with a late response present
    accept(8'h07, 1'b0, 2'd0);
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) early++;
    end
    check("to_not_early", 32'(early), 32'd0);
    @(posedge clk); #1;
    check("to_out_valid", 32'(out_valid), 32'd1);
    check("to_out_err", 32'(out_err), 32'd1);
    check("to_out_data", 32'(out_data), 32'd0);
    check("to_out_rebuilt", 32'(out_rebuilt), 32'd0);
    check("to_out_add", 32'(out_add), 32'h07);
    mem_valid = 1'b1; mem_data = {12'h777, 12'h666, 12'h555};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_err", 32'(out_err), 32'd1);
      check("bp_out_data", 32'(out_data), 32'd0);
      check("bp_rd_ready", 32'(rd_ready), 32'd0);
    end
    mem_valid = 1'b0; mem_data = 36'h0;
    handshake();

    // Response arriving on the timeout cycle wins
    accept(8'h05, 1'b0, 2'd0);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
    end
    check("tw_not_early", 32'(out_valid), 32'd0);
    mem_valid = 1'b1; mem_data = {12'h999, 12'h246, 12'h135};
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_data = 36'h0;
    check("tw_out_valid", 32'(out_valid), 32'd1);
    check("tw_out_err", 32'(out_err), 32'd0);
    check("tw_out_data", 32'(out_data), 32'h246135);
    handshake();

    // Reset while waiting: abort, ignore the stale response, then recover
    accept(8'h04, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rw_rd_ready", 32'(rd_ready), 32'd1);
    check("rw_out_valid", 32'(out_valid), 32'd0);
    check("rw_mem_en", 32'(mem_en), 32'd0);
    #2 reset_n = 1'b1;
    mem_valid = 1'b1; mem_data = {12'h111, 12'h222, 12'h333};
    repeat (2) @(posedge clk);
    #1;
    mem_valid = 1'b0; mem_data = 36'h0;
    check("rw_stale_ignored", 32'(out_valid), 32'd0);
    check("rw_stale_data", 32'(out_data), 32'd0);
    run_vec(vecs[0]);

    // Reset while a response is pending drops it
    accept(8'h03, 1'b0, 2'd0);
    mem_valid = 1'b1; mem_data = {12'h0CC, 12'h0BB, 12'h0AA};
    repeat (2) @(posedge clk);
    #1;
    mem_valid = 1'b0; mem_data = 36'h0;
    check("rr_out_valid_pre", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rr_out_valid", 32'(out_valid), 32'd0);
    check("rr_out_data", 32'(out_data), 32'd0);
    check("rr_out_add", 32'(out_add), 32'd0);
    check("rr_rd_ready", 32'(rd_ready), 32'd1);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
